// File: rtl/vga_timing_ctrl_pkg.sv
// Shared definitions for the VGA timing controller: default 640x480@60
// timing, axis-state encoding, derived totals and small helper functions.
package vga_timing_ctrl_pkg;

  // Counter width used by both axes; totals must fit in this width.
  localparam int unsigned CNT_W = 10;
  localparam int unsigned RGB_W = 6;

  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // Default horizontal timing in pixels.
  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_FP     = 16;
  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BP     = 48;

  // Default vertical timing in lines.
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FP     = 10;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BP     = 33;

  // Sync pulses are active-low in the standard 640x480 mode.
  localparam bit DEF_SYNC_NEG = 1'b1;

  // Length of one full axis period.
  function automatic int unsigned axis_total(
    input int unsigned active,
    input int unsigned fp,
    input int unsigned sync,
    input int unsigned bp
  );
    return active + fp + sync + bp;
  endfunction

  localparam int unsigned DEF_H_TOTAL =
    axis_total(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
  localparam int unsigned DEF_V_TOTAL =
    axis_total(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);

  // Region of an axis; both axes walk ACTIVE -> FRONT -> SYNC -> BACK.
  typedef enum logic [1:0] {
    AXIS_ACTIVE = 2'd0,
    AXIS_FRONT  = 2'd1,
    AXIS_SYNC   = 2'd2,
    AXIS_BACK   = 2'd3
  } axis_state_e;

  // Pin level of a sync signal: asserted level flips when active-low.
  function automatic logic sync_level(input logic in_sync, input logic neg);
    return in_sync ^ neg;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis: position counter plus ACTIVE/FRONT/SYNC/BACK state
// machine. The counter advances only when step is high; wrap flags the
// step that returns the count to zero so the next axis can be chained.
module vga_axis_counter
  import vga_timing_ctrl_pkg::*;
#(
  parameter int unsigned ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned FP     = DEF_H_FP,
  parameter int unsigned SYNC   = DEF_H_SYNC,
  parameter int unsigned BP     = DEF_H_BP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             step,
  output logic [CNT_W-1:0] cnt,
  output logic             in_active,
  output logic             in_sync,
  output logic             wrap
);

  localparam int unsigned TOTAL = axis_total(ACTIVE, FP, SYNC, BP);

  // Counts at which each region begins; ACTIVE begins at zero.
  localparam logic [CNT_W-1:0] FRONT_START = CNT_W'(ACTIVE);
  localparam logic [CNT_W-1:0] SYNC_START  = CNT_W'(ACTIVE + FP);
  localparam logic [CNT_W-1:0] BACK_START  = CNT_W'(ACTIVE + FP + SYNC);
  localparam logic [CNT_W-1:0] LAST_CNT    = CNT_W'(TOTAL - 1);

  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;
  axis_state_e      state_r;
  axis_state_e      state_nxt_s;
  logic             at_last_s;
  logic             state_ok_s;

  // Region a given count belongs to; used to detect a state that has
  // drifted away from the count and to pull it back in line.
  function automatic axis_state_e region_of(input logic [CNT_W-1:0] c);
    axis_state_e r;
    if (c < FRONT_START) begin
      r = AXIS_ACTIVE;
    end else if (c < SYNC_START) begin
      r = AXIS_FRONT;
    end else if (c < BACK_START) begin
      r = AXIS_SYNC;
    end else begin
      r = AXIS_BACK;
    end
    return r;
  endfunction

  // Terminal count; anything past the end is treated as terminal so an
  // out-of-range value wraps to zero on the next step.
  always_comb begin
    at_last_s  = (cnt_r >= LAST_CNT);
    state_ok_s = (state_r == region_of(cnt_r));
  end

  // Next count: hold when not stepping, wrap at the terminal count.
  always_comb begin
    cnt_nxt_s = cnt_r;
    if (!step) begin
      cnt_nxt_s = cnt_r;
    end else if (at_last_s) begin
      cnt_nxt_s = CNT_ZERO;
    end else begin
      cnt_nxt_s = cnt_r + CNT_ONE;
    end
  end

  // Next state: move to the following region when the stepped count
  // reaches that region's first value; a wrap always lands in ACTIVE.
  always_comb begin
    state_nxt_s = state_r;
    if (!step) begin
      state_nxt_s = state_r;
    end else if (cnt_nxt_s == CNT_ZERO) begin
      state_nxt_s = AXIS_ACTIVE;
    end else if (!state_ok_s) begin
      state_nxt_s = region_of(cnt_nxt_s);
    end else begin
      case (state_r)
        AXIS_ACTIVE: begin
          if (cnt_nxt_s == FRONT_START) begin
            state_nxt_s = AXIS_FRONT;
          end else begin
            state_nxt_s = AXIS_ACTIVE;
          end
        end
        AXIS_FRONT: begin
          if (cnt_nxt_s == SYNC_START) begin
            state_nxt_s = AXIS_SYNC;
          end else begin
            state_nxt_s = AXIS_FRONT;
          end
        end
        AXIS_SYNC: begin
          if (cnt_nxt_s == BACK_START) begin
            state_nxt_s = AXIS_BACK;
          end else begin
            state_nxt_s = AXIS_SYNC;
          end
        end
        AXIS_BACK: begin
          state_nxt_s = AXIS_BACK;
        end
        default: begin
          state_nxt_s = AXIS_ACTIVE;
        end
      endcase
    end
  end

  // Counter and state registers with synchronous reset to the origin.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r   <= CNT_ZERO;
      state_r <= AXIS_ACTIVE;
    end else begin
      cnt_r   <= cnt_nxt_s;
      state_r <= state_nxt_s;
    end
  end

  assign cnt       = cnt_r;
  assign in_active = (state_r == AXIS_ACTIVE);
  assign in_sync   = (state_r == AXIS_SYNC);
  assign wrap      = step & at_last_s;

endmodule

// File: rtl/vga_timing_ctrl.sv
// VGA timing controller: a horizontal and a vertical axis counter (the
// vertical one stepped by horizontal wraps) feeding a single registered
// output stage, so pixel data and all timing outputs stay aligned.
module vga_timing_ctrl
  import vga_timing_ctrl_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP,
  parameter bit          SYNC_NEG = DEF_SYNC_NEG
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [5:0] rgb_in,
  output logic [9:0] hpos,
  output logic [9:0] vpos,
  output logic [5:0] rgb_out,
  output logic       hsync,
  output logic       vsync,
  output logic       de,
  output logic       frame_start
);

  logic [CNT_W-1:0] h_cnt_s;
  logic [CNT_W-1:0] v_cnt_s;
  logic             h_active_s;
  logic             h_sync_s;
  logic             h_wrap_s;
  logic             v_active_s;
  logic             v_sync_s;
  logic             frame_wrap_unused_s;
  logic             pix_active_s;

  logic [RGB_W-1:0] rgb_nxt_s;
  logic             de_nxt_s;
  logic             fs_nxt_s;
  logic             hs_nxt_s;
  logic             vs_nxt_s;

  logic [RGB_W-1:0] rgb_r;
  logic             de_r;
  logic             fs_r;
  logic             hs_r;
  logic             vs_r;

  vga_axis_counter #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP)
  ) u_h_axis (
    .clk       (clk),
    .rst       (rst),
    .step      (en),
    .cnt       (h_cnt_s),
    .in_active (h_active_s),
    .in_sync   (h_sync_s),
    .wrap      (h_wrap_s)
  );

  // The vertical axis moves one line each time the horizontal axis wraps,
  // so it freezes together with the horizontal axis when en is low.
  vga_axis_counter #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP)
  ) u_v_axis (
    .clk       (clk),
    .rst       (rst),
    .step      (h_wrap_s),
    .cnt       (v_cnt_s),
    .in_active (v_active_s),
    .in_sync   (v_sync_s),
    .wrap      (frame_wrap_unused_s)
  );

  assign pix_active_s = h_active_s & v_active_s;

  // Output stage inputs: blank and deassert everything while paused,
  // otherwise present the current position's timing and pixel.
  always_comb begin
    rgb_nxt_s = 6'd0;
    de_nxt_s  = 1'b0;
    fs_nxt_s  = 1'b0;
    hs_nxt_s  = SYNC_NEG;
    vs_nxt_s  = SYNC_NEG;
    if (en) begin
      de_nxt_s = pix_active_s;
      if (pix_active_s) begin
        rgb_nxt_s = rgb_in;
      end else begin
        rgb_nxt_s = 6'd0;
      end
      fs_nxt_s = pix_active_s & (h_cnt_s == CNT_ZERO) & (v_cnt_s == CNT_ZERO);
      hs_nxt_s = sync_level(h_sync_s, SYNC_NEG);
      vs_nxt_s = sync_level(v_sync_s, SYNC_NEG);
    end else begin
      rgb_nxt_s = 6'd0;
      de_nxt_s  = 1'b0;
      fs_nxt_s  = 1'b0;
      hs_nxt_s  = SYNC_NEG;
      vs_nxt_s  = SYNC_NEG;
    end
  end

  // One-cycle output pipeline; reset drives blank video and idle syncs.
  always_ff @(posedge clk) begin
    if (rst) begin
      rgb_r <= 6'd0;
      de_r  <= 1'b0;
      fs_r  <= 1'b0;
      hs_r  <= SYNC_NEG;
      vs_r  <= SYNC_NEG;
    end else begin
      rgb_r <= rgb_nxt_s;
      de_r  <= de_nxt_s;
      fs_r  <= fs_nxt_s;
      hs_r  <= hs_nxt_s;
      vs_r  <= vs_nxt_s;
    end
  end

  assign hpos        = h_cnt_s;
  assign vpos        = v_cnt_s;
  assign rgb_out     = rgb_r;
  assign de          = de_r;
  assign frame_start = fs_r;
  assign hsync       = hs_r;
  assign vsync       = vs_r;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Bench for vga_timing_ctrl: a default 640x480 instance for line-level
// behaviour and a small-timing instance (active-high syncs) for frame-level
// behaviour. A per-cycle reference model pushes expected outputs into a
// queue per instance; a monitor pops and compares them. Directed checks
// with hand-computed numbers cover the called-out boundary cases.
module tb_vga_timing_ctrl;

  typedef struct packed {
    logic [9:0] h;
    logic [9:0] v;
    logic [5:0] rgb;
    logic       hs;
    logic       vs;
    logic       de;
    logic       fs;
  } obs_t;

  logic       clk;
  logic       rst_a, en_a, rst_b, en_b;
  logic [5:0] rgb_a, rgb_b, rgb_out_a, rgb_out_b;
  logic [9:0] hpos_a, vpos_a, hpos_b, vpos_b;
  logic       hsync_a, vsync_a, de_a, fs_a;
  logic       hsync_b, vsync_b, de_b, fs_b;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   mh_a = 0, mv_a = 0, mh_b = 0, mv_b = 0;
  obs_t q_a[$];
  obs_t q_b[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign rgb_a = hpos_a[5:0];
  assign rgb_b = hpos_b[5:0];

  vga_timing_ctrl u_dut_a (
    .clk(clk), .rst(rst_a), .en(en_a), .rgb_in(rgb_a),
    .hpos(hpos_a), .vpos(vpos_a), .rgb_out(rgb_out_a),
    .hsync(hsync_a), .vsync(vsync_a), .de(de_a), .frame_start(fs_a)
  );

  vga_timing_ctrl #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
    .V_ACTIVE(6),  .V_FP(2), .V_SYNC(2), .V_BP(3),
    .SYNC_NEG(1'b0)
  ) u_dut_b (
    .clk(clk), .rst(rst_b), .en(en_b), .rgb_in(rgb_b),
    .hpos(hpos_b), .vpos(vpos_b), .rgb_out(rgb_out_b),
    .hsync(hsync_b), .vsync(vsync_b), .de(de_b), .frame_start(fs_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Expected registered outputs for one edge, from the position before it.
  function automatic obs_t model_out(input int h, input int v, input logic r, input logic e,
                                     input int ha, input int hf, input int hsw,
                                     input int va, input int vf, input int vsw, input bit neg);
    obs_t o;
    logic act;
    o     = '0;
    o.hs  = neg;
    o.vs  = neg;
    act   = (h < ha) && (v < va);
    if (!r && e) begin
      o.de  = act;
      o.rgb = act ? 6'(h) : 6'd0;
      o.fs  = act && (h == 0) && (v == 0);
      o.hs  = ((h >= ha + hf) && (h < ha + hf + hsw)) ? ~neg : neg;
      o.vs  = ((v >= va + vf) && (v < va + vf + vsw)) ? ~neg : neg;
    end
    return o;
  endfunction

  task automatic advance(input logic r, input logic e, input int ht, input int vt,
                         input int h, input int v, output int nh, output int nv);
    nh = h;
    nv = v;
    if (r) begin
      nh = 0;
      nv = 0;
    end else if (e) begin
      if (h == ht - 1) begin
        nh = 0;
        nv = (v == vt - 1) ? 0 : v + 1;
      end else begin
        nh = h + 1;
      end
    end
  endtask

  task automatic sb_compare(input string tag, input obs_t got, input obs_t exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got h=%0d v=%0d rgb=%0h hs=%b vs=%b de=%b fs=%b, expected h=%0d v=%0d rgb=%0h hs=%b vs=%b de=%b fs=%b",
               tag, got.h, got.v, got.rgb, got.hs, got.vs, got.de, got.fs,
               exp.h, exp.v, exp.rgb, exp.hs, exp.vs, exp.de, exp.fs);
    end
  endtask

  // Reference model: on each edge push what both DUTs should show after it.
  initial begin : model_proc
    obs_t o;
    forever begin
      @(posedge clk);
      o = model_out(mh_a, mv_a, rst_a, en_a, 640, 16, 96, 480, 10, 2, 1'b1);
      advance(rst_a, en_a, 800, 525, mh_a, mv_a, mh_a, mv_a);
      o.h = 10'(mh_a);
      o.v = 10'(mv_a);
      q_a.push_back(o);
      o = model_out(mh_b, mv_b, rst_b, en_b, 16, 2, 4, 6, 2, 2, 1'b0);
      advance(rst_b, en_b, 25, 13, mh_b, mv_b, mh_b, mv_b);
      o.h = 10'(mh_b);
      o.v = 10'(mv_b);
      q_b.push_back(o);
    end
  end

  // Monitor: every cycle both DUTs present a result; pop and compare.
  initial begin : monitor_proc
    forever begin
      @(posedge clk);
      #1;
      if (q_a.size() == 0) check("sb_a_empty", 32'd0, 32'd1);
      else sb_compare("sb_a", {hpos_a, vpos_a, rgb_out_a, hsync_a, vsync_a, de_a, fs_a}, q_a.pop_front());
      if (q_b.size() == 0) check("sb_b_empty", 32'd0, 32'd1);
      else sb_compare("sb_b", {hpos_b, vpos_b, rgb_out_b, hsync_b, vsync_b, de_b, fs_b}, q_b.pop_front());
    end
  end

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int de_cnt, hs_cnt, hs_first, hs_last, fs_cnt, fs_at;
    int vs_cnt, vs_first;
    rst_a = 1'b1; en_a = 1'b0; rst_b = 1'b1; en_b = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_hpos", 32'(hpos_a), 32'd0);
    check("rst_vpos", 32'(vpos_a), 32'd0);
    check("rst_hsync", 32'(hsync_a), 32'd1);
    check("rst_vsync", 32'(vsync_a), 32'd1);
    check("rst_de", 32'(de_a), 32'd0);
    check("rst_fs", 32'(fs_a), 32'd0);
    check("rst_rgb", 32'(rgb_out_a), 32'd0);

    // One full line after reset release.
    rst_a = 1'b0; en_a = 1'b1;
    de_cnt = 0; hs_cnt = 0; hs_first = 0; hs_last = 0; fs_cnt = 0; fs_at = 0;
    for (int k = 1; k <= 800; k++) begin
      @(negedge clk);
      if (de_a) de_cnt++;
      if (!hsync_a) begin
        hs_cnt++;
        if (hs_first == 0) hs_first = k;
        hs_last = k;
      end
      if (fs_a) begin
        fs_cnt++;
        fs_at = k;
      end
      if (k == 1) begin
        check("first_de", 32'(de_a), 32'd1);
        check("first_rgb", 32'(rgb_out_a), 32'h00);
      end
      if (k == 38) check("rgb_h37", 32'(rgb_out_a), 32'd37);
      if (k == 700) check("rgb_blank", 32'(rgb_out_a), 32'd0);
    end
    check("line_de_count", 32'(de_cnt), 32'd640);
    check("line_hs_count", 32'(hs_cnt), 32'd96);
    check("line_hs_first", 32'(hs_first), 32'd657);
    check("line_hs_last", 32'(hs_last), 32'd752);
    check("line_fs_count", 32'(fs_cnt), 32'd1);
    check("line_fs_cycle", 32'(fs_at), 32'd1);
    check("line_end_hpos", 32'(hpos_a), 32'd0);
    check("line_end_vpos", 32'(vpos_a), 32'd1);

    // Pause for 50 cycles at hpos 300 of line 1.
    repeat (300) @(negedge clk);
    check("pause_hpos_pre", 32'(hpos_a), 32'd300);
    en_a = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      check("pause_hpos", 32'(hpos_a), 32'd300);
      check("pause_de", 32'(de_a), 32'd0);
      check("pause_sync", 32'({hsync_a, vsync_a}), 32'd3);
    end
    en_a = 1'b1;
    @(negedge clk);
    check("resume_hpos", 32'(hpos_a), 32'd301);
    check("resume_vpos", 32'(vpos_a), 32'd1);

    // Reset in the middle of the hsync pulse.
    repeat (399) @(negedge clk);
    check("mid_hsync_hpos", 32'(hpos_a), 32'd700);
    check("mid_hsync_low", 32'(hsync_a), 32'd0);
    rst_a = 1'b1;
    @(negedge clk);
    check("mid_rst_hpos", 32'(hpos_a), 32'd0);
    check("mid_rst_vpos", 32'(vpos_a), 32'd0);
    check("mid_rst_hsync", 32'(hsync_a), 32'd1);
    check("mid_rst_vsync", 32'(vsync_a), 32'd1);
    check("mid_rst_de", 32'(de_a), 32'd0);

    // Small-timing instance: 25 x 13, full frame of 325 cycles.
    check("b_rst_hsync", 32'(hsync_b), 32'd0);
    check("b_rst_vsync", 32'(vsync_b), 32'd0);
    rst_b = 1'b0; en_b = 1'b1;
    vs_cnt = 0; vs_first = 0; fs_cnt = 0; fs_at = 0;
    for (int k = 1; k <= 326; k++) begin
      @(negedge clk);
      if (vsync_b) begin
        vs_cnt++;
        if (vs_first == 0) vs_first = k;
      end
      if (fs_b) begin
        fs_cnt++;
        fs_at = k;
      end
      if (k == 19) check("b_hsync_on", 32'(hsync_b), 32'd1);
      if (k == 324) begin
        check("b_last_hpos", 32'(hpos_b), 32'd24);
        check("b_last_vpos", 32'(vpos_b), 32'd12);
      end
      if (k == 325) begin
        check("b_wrap_hpos", 32'(hpos_b), 32'd0);
        check("b_wrap_vpos", 32'(vpos_b), 32'd0);
      end
    end
    check("b_vs_count", 32'(vs_cnt), 32'd50);
    check("b_vs_first", 32'(vs_first), 32'd201);
    check("b_fs_count", 32'(fs_cnt), 32'd2);
    check("b_fs_second", 32'(fs_at), 32'd326);

    // Reset while both syncs are asserted: counters at (19,9) of frame 2.
    repeat (243) @(negedge clk);
    check("b_pre_hpos", 32'(hpos_b), 32'd19);
    check("b_pre_vpos", 32'(vpos_b), 32'd9);
    check("b_pre_syncs", 32'({hsync_b, vsync_b}), 32'd3);
    rst_b = 1'b1;
    @(negedge clk);
    check("b_rst_pos", 32'({hpos_b, vpos_b}), 32'd0);
    check("b_rst_syncs", 32'({hsync_b, vsync_b}), 32'd0);
    check("b_rst_de_fs", 32'({de_b, fs_b}), 32'd0);
    check("b_rst_rgb", 32'(rgb_out_b), 32'd0);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
